// File: rtl/sonata_clk_rst_gen.sv
// System clock and reset generator: even-ratio clock divider, emulated PLL lock
// and an active-low system reset released on a falling edge of the divided clock.
module sonata_clk_rst_gen #(
  parameter int ClkDiv        = 2,
  parameter int LockCycles    = 64,
  parameter int RstHoldCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic clk_buf_o,
  output logic clk_sys_o,
  output logic clk_sys_en_o,
  output logic locked_o,
  output logic rst_sys_n_o
);

  localparam int DivW  = $clog2(ClkDiv);
  localparam int LockW = (LockCycles > 1) ? $clog2(LockCycles) : 1;
  localparam int HoldW = (RstHoldCycles > 1) ? $clog2(RstHoldCycles) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(ClkDiv - 1);
  localparam logic [DivW-1:0]  DivHalf  = DivW'(ClkDiv / 2);
  localparam logic [LockW-1:0] LockLast = LockW'(LockCycles - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RstHoldCycles - 1);

  logic [DivW-1:0]  div_cnt;
  logic [DivW-1:0]  div_cnt_next;
  logic [LockW-1:0] lock_cnt;
  logic [HoldW-1:0] hold_cnt;
  logic             fall_evt;

  assign clk_buf_o = clk_i;

  always_comb begin
    div_cnt_next = (div_cnt == DivLast) ? '0 : div_cnt + 1'b1;
    fall_evt     = (div_cnt_next == DivHalf);
  end

  // Divider: clk_sys_o mirrors (div_cnt < ClkDiv/2) one register stage ahead
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt      <= DivLast;
      clk_sys_o    <= 1'b0;
      clk_sys_en_o <= 1'b0;
    end else begin
      div_cnt      <= div_cnt_next;
      clk_sys_o    <= (div_cnt_next < DivHalf);
      clk_sys_en_o <= (div_cnt_next == DivLast);
    end
  end

  // Lock emulation: counter parks at its last value once locked
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_cnt <= '0;
      locked_o <= 1'b0;
    end else if (!locked_o) begin
      if (lock_cnt == LockLast) begin
        locked_o <= 1'b1;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  // Reset release: gated on the registered lock, so the locking edge never counts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt    <= '0;
      rst_sys_n_o <= 1'b0;
    end else if (locked_o && !rst_sys_n_o && fall_evt) begin
      if (hold_cnt == HoldLast) begin
        rst_sys_n_o <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sonata_clk_rst_gen.sv
// Scoreboard bench for sonata_clk_rst_gen: ClkDiv=2 and ClkDiv=4 instances side by side,
// expectations derived from the edge count since reset release.
module tb_sonata_clk_rst_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic buf2, sys2, en2, lk2, rn2;
  logic buf4, sys4, en4, lk4, rn4;

  int n_cmp = 0;
  int n_err = 0;
  int n_edge = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  sonata_clk_rst_gen #(.ClkDiv(2), .LockCycles(64), .RstHoldCycles(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .clk_buf_o(buf2), .clk_sys_o(sys2),
    .clk_sys_en_o(en2), .locked_o(lk2), .rst_sys_n_o(rn2)
  );

  sonata_clk_rst_gen #(.ClkDiv(4), .LockCycles(64), .RstHoldCycles(16)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .clk_buf_o(buf4), .clk_sys_o(sys4),
    .clk_sys_en_o(en4), .locked_o(lk4), .rst_sys_n_o(rn4)
  );

  // Expected {clk_sys, clk_sys_en, locked, rst_sys_n} after edge n since release
  // (n == 0 means reset was sampled). rel is the edge at which rst_sys_n rises.
  function automatic logic [3:0] exp_out(input int n, input int d, input int rel);
    logic c, e, l, r;
    if (n == 0) return 4'b0000;
    c = ((n - 1) % d) < (d / 2);
    e = ((n - 1) % d) == (d - 1);
    l = (n >= 64);
    r = (n >= rel);
    return {c, e, l, r};
  endfunction

  // Push the expectation for the coming edge, then advance past it
  task automatic drive_edge();
    n_edge = rst ? 0 : n_edge + 1;
    sb_q.push_back({exp_out(n_edge, 2, 96), exp_out(n_edge, 4, 127)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_edge();
      exp = sb_q.pop_front();
      n_cmp++;
      if ({sys2, en2, lk2, rn2, sys4, en4, lk4, rn4} !== exp) begin
        n_err++;
        $display("FAIL reset_outputs edge=%0d got=%b want=%b", i,
                 {sys2, en2, lk2, rn2, sys4, en4, lk4, rn4}, exp);
      end
      n_cmp++;
      if ({buf2, buf4} !== 2'b11) begin
        n_err++;
        $display("FAIL clk_buf_high got=%b want=11", {buf2, buf4});
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({buf2, buf4} !== 2'b00) begin
        n_err++;
        $display("FAIL clk_buf_low got=%b want=00", {buf2, buf4});
      end
      @(posedge clk);
      #1;
      n_edge = 0;
    end
  endtask

  task automatic test_run(input string name, input int edges);
    logic [7:0] exp;
    for (int i = 0; i < edges; i++) begin
      drive_edge();
      exp = sb_q.pop_front();
      n_cmp++;
      if ({sys2, en2, lk2, rn2, sys4, en4, lk4, rn4} !== exp) begin
        n_err++;
        $display("FAIL %s edge=%0d got=%b want=%b", name, n_edge,
                 {sys2, en2, lk2, rn2, sys4, en4, lk4, rn4}, exp);
      end
    end
  endtask

  task automatic test_divider();
    rst = 1'b0;
    test_run("divider", 8);
  endtask

  task automatic test_lock_release();
    logic [7:0] exp;
    test_run("lock_release", 141);
    n_cmp++;
    if ({lk2, rn2, lk4, rn4} !== 4'b1111) begin
      n_err++;
      $display("FAIL released_state got=%b want=1111", {lk2, rn2, lk4, rn4});
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp;
    rst = 1'b1;
    drive_edge();
    exp = sb_q.pop_front();
    n_cmp++;
    if ({sys2, en2, lk2, rn2, sys4, en4, lk4, rn4} !== exp) begin
      n_err++;
      $display("FAIL mid_reset got=%b want=%b",
               {sys2, en2, lk2, rn2, sys4, en4, lk4, rn4}, exp);
    end
    rst = 1'b0;
    test_run("after_mid_reset", 140);
  endtask

  task automatic test_sticky();
    test_run("sticky", 1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divider();
    test_lock_release();
    test_mid_reset();
    test_sticky();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sonata_clk_rst_gen.md
Name: sonata_clk_rst_gen

Overview:
- Portable, synthesizable system clock and reset generator for the Sonata top level.
- Derives the system clock from the board reference clock by even integer division.
- Emulates PLL lock with a fixed cycle count.
- Produces the active-low system reset consumed by ibex_demo_system (`rst_sys_ni`). Reset deasserts only after lock plus a hold period, aligned to a system-clock falling edge.

Parameters:
- ClkDiv, default 2: even integer ≥ 2. clk_sys_o = clk_i / ClkDiv, 50% duty.
- LockCycles, default 64: clk_i edges after reset release before locked_o asserts. Must be ≥ 1.
- RstHoldCycles, default 16: clk_sys falling edges, counted after lock, before rst_sys_n_o deasserts. Must be ≥ 1.

Ports:
- clk_i  in  1  board reference clock; the only clock in the block.
- rst_i  in  1  synchronous, active-high reset.
- clk_buf_o  out  1  buffered copy of clk_i (direct pass-through).
- clk_sys_o  out  1  divided system clock, registered.
- clk_sys_en_o  out  1  registered; high during the clk_i cycle that immediately precedes each clk_sys_o rising edge.
- locked_o  out  1  emulated PLL lock indication.
- rst_sys_n_o  out  1  active-low system reset.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on the clk_i rising edge only. No combinational path from any input to any output except clk_buf_o = clk_i.
- Values while rst_i = 1 (sampled at a clk_i edge):
  - div_cnt = ClkDiv-1
  - clk_sys_o = 0
  - clk_sys_en_o = 0
  - lock_cnt = 0
  - locked_o = 0
  - hold_cnt = 0
  - rst_sys_n_o = 0
- Divider:
  - div_cnt_next = (div_cnt == ClkDiv-1) ? 0 : div_cnt+1.
  - clk_sys_o <= (div_cnt_next < ClkDiv/2). Invariant: clk_sys_o == (div_cnt < ClkDiv/2).
  - clk_sys_en_o <= (div_cnt_next == ClkDiv-1).
  - The first clk_i edge after reset release sets clk_sys_o = 1.
  - The divider free-runs regardless of lock state.
- Falling event: the clk_i edge at which clk_sys_o goes 1→0, i.e. div_cnt_next == ClkDiv/2.
- Lock:
  - While locked_o = 0, lock_cnt increments every edge.
  - At the edge where lock_cnt == LockCycles-1, locked_o <= 1. locked_o therefore rises exactly LockCycles edges after the last reset edge.
  - locked_o is sticky until rst_i.
  - lock_cnt saturates; it does not wrap.
- Reset release:
  - While the registered locked_o = 1 and rst_sys_n_o = 0, each falling event increments hold_cnt.
  - On the falling event where hold_cnt == RstHoldCycles-1, rst_sys_n_o <= 1.
  - A falling event on the same edge that sets locked_o is not counted.
  - rst_sys_n_o changes only on falling events, which gives half a clk_sys period of setup before the next clk_sys rising edge.
  - rst_sys_n_o is sticky high until rst_i.
- Reset mid-operation: rst_i = 1 at any edge immediately restores every reset value. rst_sys_n_o drops to 0 on that same edge; assertion is not aligned to clk_sys. The full lock and hold sequence restarts after release.
- Counter widths: sized to hold ClkDiv-1, LockCycles-1 and RstHoldCycles-1 respectively. No overflow is possible.

Test Plan (ClkDiv=2, LockCycles=64, RstHoldCycles=16; edge 1 is the first clk_i edge with rst_i = 0):
- Hold rst_i = 1 for 5 edges:
  - Outputs: clk_sys_o=0, clk_sys_en_o=0, locked_o=0, rst_sys_n_o=0.
  - clk_buf_o tracks clk_i continuously.
- Release reset, divider sequence:
  - clk_sys_o = 1,0,1,0… after edges 1,2,3,4.
  - clk_sys_en_o = 0,1,0,1… after edges 1,2,3,4.
  - Period is 2 clk_i cycles, duty 50%.
- Lock timing: locked_o = 0 after edge 63 and 1 after edge 64; it stays 1 for 1000 further edges.
- Reset release timing:
  - rst_sys_n_o = 0 through edge 95; it rises at edge 96, the 16th falling event after lock.
  - At that edge clk_sys_o goes 1→0.
  - rst_sys_n_o remains 1 thereafter.
- Mid-operation reset: assert rst_i at edge 150 for 1 cycle.
  - All outputs return to their reset values at that edge.
  - After release, locked_o rises 64 edges later and rst_sys_n_o rises 96 edges later.
- ClkDiv=4 variant:
  - clk_sys_o pattern is 1,1,0,0 per 4 edges.
  - clk_sys_en_o is high only on the 4th edge of each group.
  - rst_sys_n_o rises on the 16th post-lock falling event (div_cnt becomes 2).
